mem_access_unit: RTL and testbench

MEM-stage memory access engine that consumes the EX/MEM pipeline register outputs and performs the load or store on a req/ack data bus. It drives a multi-cycle handshake, holds the pipeline through `stall_o` while the access is outstanding, handles byte-lane steering and load extension, and returns load data to the MEM/WB path. `stall_o` feeds the `writeEN` inputs of the upstream pipeline registers; `clr` is not driven by this block.

---
 rtl/mem_pkg.sv | 41 ++++
 rtl/load_align.sv | 29 ++
 rtl/mem_access_unit.sv | 143 ++++++++++++++
 tb/tb_mem_access_unit.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// mem_pkg: shared constants and types for the MEM-stage access engine.
//   FSM state encoding, read_sel / write_sel encodings, default bus wait
//   limit, wait-counter width and the latched request payload.
package mem_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Load type (read_sel); 2'b11 behaves as a word load
  localparam logic [1:0] RSEL_LW     = 2'b00;
  localparam logic [1:0] RSEL_LB     = 2'b01;
  localparam logic [1:0] RSEL_LBU    = 2'b10;
  localparam logic [1:0] RSEL_LW_ALT = 2'b11;

  // Store type (write_sel)
  localparam logic WSEL_SW = 1'b0;
  localparam logic WSEL_SB = 1'b1;

  localparam int unsigned MAX_WAIT_DEFAULT = 15;
  localparam int unsigned CNT_W            = 8;

  // Request captured in IDLE and presented on the bus during REQ
  typedef struct packed {
    logic        isRead;
    logic [1:0]  readSel;
    logic [1:0]  byteOff;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
  } memReq_t;

  // True for LW/SW-class accesses (reads take priority when both are set)
  function automatic logic isWordAccess(input logic isRead, input logic [1:0] readSel,
                                        input logic writeSel);
    if (isRead) return !((readSel == RSEL_LB) || (readSel == RSEL_LBU));
    return writeSel == WSEL_SW;
  endfunction

endpackage

// File: rtl/load_align.sv
// load_align: selects the byte lane of a loaded word and extends it.
//   word    - raw bus read data
//   byteOff - addr[1:0] of the load
//   readSel - load type (LW, LB, LBU, 11 = LW)
//   result  - extended 32-bit load value
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byteOff,
  input  logic [1:0]  readSel,
  output logic [31:0] result
);

  logic [7:0] lane;

  // Little-endian lane select, then sign/zero extension by load type
  always_comb begin
    lane   = word[{byteOff, 3'b000} +: 8];
    result = word;
    case (readSel)
      RSEL_LB:              result = {{24{lane[7]}}, lane};
      RSEL_LBU:             result = {24'd0, lane};
      RSEL_LW, RSEL_LW_ALT: result = word;
      default:              result = word;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine on a req/ack data bus.
//   Accepts an access from EX/MEM, holds the pipeline via stall_o while the
//   bus request is outstanding, steers byte lanes, extends loads and pulses
//   done_o (and timeout_o when no ack arrives within MAX_WAIT REQ cycles).
//   Ports: clk, rst (async, active-high); mem_read_i/mem_write_i/read_sel_i/
//   write_sel_i/addr_i/wdata_i from EX/MEM; bus_* req/ack bus; stall_o
//   (combinational) to upstream writeEN; load_data_o, done_o, timeout_o,
//   exc_align_o to MEM/WB and flush logic.
//   Optional macro MEM_ALIGN_CHECK_EN: misaligned LW/SW raise exc_align_o
//   instead of issuing a bus access; otherwise word accesses are forced aligned.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int unsigned MAX_WAIT = MAX_WAIT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read_i,
  input  logic        mem_write_i,
  input  logic [1:0]  read_sel_i,
  input  logic        write_sel_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_be_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        stall_o,
  output logic [31:0] load_data_o,
  output logic        done_o,
  output logic        timeout_o,
  output logic        exc_align_o
);

  logic [1:0]       state, stateNext;
  logic [CNT_W-1:0] waitCnt, cntNext;
  logic             accessPresent, misaligned, accept, ackHit, timeoutHit;
  memReq_t          req, newReq;
  logic [31:0]      loadValue;

  assign accessPresent = mem_read_i | mem_write_i;

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned  = accessPresent && (addr_i[1:0] != 2'b00) &&
                       isWordAccess(mem_read_i, read_sel_i, write_sel_i);
  // Raised in the IDLE cycle itself so flush logic sees it with the instruction
  assign exc_align_o = (state == ST_IDLE) && misaligned;
`else
  assign misaligned  = 1'b0;
  assign exc_align_o = 1'b0;
`endif

  assign accept = (state == ST_IDLE) && accessPresent && !misaligned;

  // Build the bus payload from the EX/MEM inputs
  always_comb begin
    newReq         = '0;
    newReq.isRead  = mem_read_i;
    newReq.readSel = read_sel_i;
    newReq.byteOff = addr_i[1:0];
    newReq.addr    = {addr_i[31:2], 2'b00};
    newReq.be      = 4'b1111;
    newReq.wdata   = wdata_i;
    if (!mem_read_i && (write_sel_i == WSEL_SB)) begin
      newReq.be    = 4'b0001 << addr_i[1:0];
      newReq.wdata = {4{wdata_i[7:0]}};
    end
  end

  // Next state, wait counter and stall
  always_comb begin
    stateNext  = state;
    cntNext    = waitCnt;
    stall_o    = 1'b0;
    ackHit     = 1'b0;
    timeoutHit = 1'b0;
    case (state)
      ST_IDLE: begin
        stall_o = accessPresent && !misaligned;
        if (accept) begin
          stateNext = ST_REQ;
          cntNext   = '0;
        end
      end
      ST_REQ: begin
        stall_o    = 1'b1;
        ackHit     = bus_ack_i;
        // waitCnt counts earlier REQ cycles; an ack on the last one still wins
        timeoutHit = !bus_ack_i && (waitCnt == CNT_W'(MAX_WAIT - 1));
        cntNext    = waitCnt + CNT_W'(1);
        if (ackHit || timeoutHit) stateNext = ST_DONE;
      end
      ST_DONE: stateNext = ST_IDLE;
      default: stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= cntNext;
    end
  end

  load_align uLoadAlign (
    .word    (bus_rdata_i),
    .byteOff (req.byteOff),
    .readSel (req.readSel),
    .result  (loadValue)
  );

  // Registered bus controls, completion pulses and load result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req         <= '0;
      bus_req_o   <= 1'b0;
      bus_we_o    <= 1'b0;
      done_o      <= 1'b0;
      timeout_o   <= 1'b0;
      load_data_o <= '0;
    end else begin
      if (accept) req <= newReq;
      bus_req_o <= (stateNext == ST_REQ);
      bus_we_o  <= (stateNext == ST_REQ) &&
                   ((state == ST_IDLE) ? !newReq.isRead : !req.isRead);
      done_o    <= (stateNext == ST_DONE);
      timeout_o <= timeoutHit;
      if (ackHit && req.isRead) load_data_o <= loadValue;
      else if (timeoutHit)      load_data_o <= '0;
    end
  end

  assign bus_addr_o  = req.addr;
  assign bus_be_o    = req.be;
  assign bus_wdata_o = req.wdata;

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: self-checking bench for mem_access_unit (MAX_WAIT = 4).
//   Directed scenarios plus randomized accesses checked against a
//   transaction-level model of addressing, lane steering and load extension.
module tb_mem_access_unit;

  localparam int unsigned MW = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i, write_sel_i;
  logic [1:0]  read_sel_i;
  logic [31:0] addr_i, wdata_i, bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_req_o, bus_we_o, stall_o, done_o, timeout_o, exc_align_o;
  logic [31:0] bus_addr_o, bus_wdata_o, load_data_o;
  logic [3:0]  bus_be_o;

  int nChecks = 0;
  int nFails  = 0;
  logic [31:0] expLoad = '0;

  always #5 clk = ~clk;

  mem_access_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .read_sel_i(read_sel_i), .write_sel_i(write_sel_i),
    .addr_i(addr_i), .wdata_i(wdata_i),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
    .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stall_o(stall_o), .load_data_o(load_data_o), .done_o(done_o),
    .timeout_o(timeout_o), .exc_align_o(exc_align_o)
  );

  // Reference load result: pick byte by offset, extend by load type
  function automatic logic [31:0] modelLoad(input logic [1:0] rsel, input logic [1:0] off,
                                            input logic [31:0] w);
    logic [7:0] b;
    logic signed [31:0] s;
    b = 8'(w >> (8 * off));
    s = $signed(b);
    if (rsel == 2'b01) return s;
    if (rsel == 2'b10) return 32'(b);
    return w;
  endfunction

  // One access; ackAt = REQ-cycle index of the ack, <0 or >=MW means none in time
  task automatic runAccess(input string tag, input logic rd, input logic wr,
                           input logic [1:0] rsel, input logic wsel,
                           input logic [31:0] addr, input logic [31:0] wd,
                           input int ackAt, input logic [31:0] rdata);
    logic [31:0] eAddr, eWd;
    logic [3:0]  eBe;
    logic        eWe, timedOut;
    int          reqCycles;
    eAddr = addr & 32'hFFFF_FFFC;
    eWe   = !rd;
    if (!rd && wsel) begin
      eBe = 4'(1 << addr[1:0]);
      eWd = 32'(wd[7:0]) * 32'h0101_0101;
    end else begin
      eBe = 4'hF;
      eWd = wd;
    end
    timedOut  = (ackAt < 0) || (ackAt >= int'(MW));
    reqCycles = timedOut ? int'(MW) : ackAt + 1;

    @(posedge clk); #1;
    mem_read_i = rd; mem_write_i = wr; read_sel_i = rsel; write_sel_i = wsel;
    addr_i = addr; wdata_i = wd;
    @(negedge clk);
    nChecks++;
    if (stall_o !== 1'b1 || bus_req_o !== 1'b0 || done_o !== 1'b0) begin
      nFails++;
      $display("FAIL %s accept: stall=%b req=%b done=%b, want 1 0 0", tag, stall_o, bus_req_o, done_o);
    end

    for (int n = 0; n < reqCycles; n++) begin
      @(posedge clk); #1;
      bus_ack_i   = (n == ackAt);
      bus_rdata_i = (n == ackAt) ? rdata : $urandom;
      @(negedge clk);
      nChecks++;
      if (bus_req_o !== 1'b1 || stall_o !== 1'b1 || done_o !== 1'b0 || bus_we_o !== eWe ||
          bus_addr_o !== eAddr || bus_be_o !== eBe || exc_align_o !== 1'b0 ||
          (eWe && bus_wdata_o !== eWd) || load_data_o !== expLoad) begin
        nFails++;
        $display("FAIL %s req%0d: req=%b stall=%b done=%b we=%b addr=%h be=%b wd=%h ld=%h, want 1 1 0 %b %h %b %h %h",
                 tag, n, bus_req_o, stall_o, done_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o,
                 load_data_o, eWe, eAddr, eBe, eWd, expLoad);
      end
    end

    @(posedge clk); #1;
    bus_ack_i = 1'b0; bus_rdata_i = $urandom;
    if (timedOut) expLoad = '0;
    else if (rd)  expLoad = modelLoad(rsel, addr[1:0], rdata);
    @(negedge clk);
    nChecks++;
    if (done_o !== 1'b1 || timeout_o !== timedOut || stall_o !== 1'b0 || bus_req_o !== 1'b0 ||
        bus_we_o !== 1'b0 || load_data_o !== expLoad) begin
      nFails++;
      $display("FAIL %s done: done=%b to=%b stall=%b req=%b we=%b ld=%h, want 1 %b 0 0 0 %h",
               tag, done_o, timeout_o, stall_o, bus_req_o, bus_we_o, load_data_o, timedOut, expLoad);
    end

    @(posedge clk); #1;
    mem_read_i = 1'b0; mem_write_i = 1'b0;
    @(negedge clk);
    nChecks++;
    if (done_o !== 1'b0 || timeout_o !== 1'b0 || stall_o !== 1'b0 || bus_req_o !== 1'b0 ||
        load_data_o !== expLoad) begin
      nFails++;
      $display("FAIL %s idle: done=%b to=%b stall=%b req=%b ld=%h, want 0 0 0 0 %h",
               tag, done_o, timeout_o, stall_o, bus_req_o, load_data_o, expLoad);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0; read_sel_i = 2'b00; write_sel_i = 1'b0;
    addr_i = '0; wdata_i = '0; bus_ack_i = 1'b0; bus_rdata_i = '0;
    repeat (2) @(negedge clk);
    nChecks++;
    if (bus_req_o !== 1'b0 || bus_we_o !== 1'b0 || bus_addr_o !== '0 || bus_be_o !== '0 ||
        bus_wdata_o !== '0 || load_data_o !== '0 || done_o !== 1'b0 || timeout_o !== 1'b0 ||
        exc_align_o !== 1'b0 || stall_o !== 1'b1) begin
      nFails++;
      $display("FAIL reset: req=%b we=%b addr=%h be=%b wd=%h ld=%h done=%b to=%b exc=%b stall=%b, want zeros, stall 1",
               bus_req_o, bus_we_o, bus_addr_o, bus_be_o, bus_wdata_o, load_data_o, done_o,
               timeout_o, exc_align_o, stall_o);
    end
    mem_read_i = 1'b0;
    #1;
    nChecks++;
    if (stall_o !== 1'b0) begin
      nFails++;
      $display("FAIL reset_stall_idle: stall=%b, want 0", stall_o);
    end
    @(posedge clk); #1; rst = 1'b0;
    expLoad = '0;
  endtask

  task automatic test_lw();
    runAccess("lw_0x100", 1'b1, 1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
    nChecks++;
    if (load_data_o !== 32'hDEAD_BEEF) begin
      nFails++;
      $display("FAIL lw_value: ld=%h, want deadbeef", load_data_o);
    end
  endtask

  task automatic test_byte_loads();
    runAccess("lb_0x103", 1'b1, 1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 1, 32'h80FF_1234);
    nChecks++;
    if (load_data_o !== 32'hFFFF_FF80) begin
      nFails++;
      $display("FAIL lb_value: ld=%h, want ffffff80", load_data_o);
    end
    runAccess("lbu_0x103", 1'b1, 1'b0, 2'b10, 1'b0, 32'h103, 32'h0, 2, 32'h80FF_1234);
    nChecks++;
    if (load_data_o !== 32'h0000_0080) begin
      nFails++;
      $display("FAIL lbu_value: ld=%h, want 00000080", load_data_o);
    end
  endtask

  task automatic test_sb();
    runAccess("sb_0x202", 1'b0, 1'b1, 2'b00, 1'b1, 32'h202, 32'h0000_00A5, 0, 32'h0);
    nChecks++;
    if (bus_be_o !== 4'b0100 || bus_wdata_o !== 32'hA5A5_A5A5 || bus_addr_o !== 32'h200) begin
      nFails++;
      $display("FAIL sb_payload: be=%b wd=%h addr=%h, want 0100 a5a5a5a5 00000200",
               bus_be_o, bus_wdata_o, bus_addr_o);
    end
  endtask

  task automatic test_timeout();
    runAccess("lw_timeout", 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0, -1, 32'h0);
    runAccess("lw_ack_at_limit", 1'b1, 1'b0, 2'b00, 1'b0, 32'h44, 32'h0, int'(MW) - 1, 32'h1357_9BDF);
    runAccess("sw_timeout", 1'b0, 1'b1, 2'b00, 1'b0, 32'h48, 32'hCAFE_F00D, -1, 32'h0);
  endtask

  task automatic test_ack_ignored();
    @(posedge clk); #1;
    bus_ack_i = 1'b1; bus_rdata_i = 32'h1111_2222;
    @(negedge clk);
    @(posedge clk); #1; bus_ack_i = 1'b0;
    @(negedge clk);
    nChecks++;
    if (done_o !== 1'b0 || bus_req_o !== 1'b0 || load_data_o !== expLoad) begin
      nFails++;
      $display("FAIL idle_ack: done=%b req=%b ld=%h, want 0 0 %h", done_o, bus_req_o, load_data_o, expLoad);
    end
  endtask

  task automatic test_reset_mid_req();
    @(posedge clk); #1;
    mem_read_i = 1'b1; read_sel_i = 2'b00; addr_i = 32'h300;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    nChecks++;
    if (bus_req_o !== 1'b0 || done_o !== 1'b0 || stall_o !== 1'b1) begin
      nFails++;
      $display("FAIL rst_mid_req: req=%b done=%b stall=%b, want 0 0 1", bus_req_o, done_o, stall_o);
    end
    @(posedge clk); #1;
    mem_read_i = 1'b0; rst = 1'b0; expLoad = '0;
    @(negedge clk);
    nChecks++;
    if (bus_req_o !== 1'b0 || stall_o !== 1'b0 || load_data_o !== 32'h0) begin
      nFails++;
      $display("FAIL rst_release: req=%b stall=%b ld=%h, want 0 0 0", bus_req_o, stall_o, load_data_o);
    end
    runAccess("lw_after_rst", 1'b1, 1'b0, 2'b00, 1'b0, 32'h304, 32'h0, 1, 32'h0BAD_F00D);
  endtask

  task automatic test_align();
`ifdef MEM_ALIGN_CHECK_EN
    @(posedge clk); #1;
    mem_write_i = 1'b1; write_sel_i = 1'b0; addr_i = 32'h102; wdata_i = 32'h1234_5678;
    @(negedge clk);
    nChecks++;
    if (exc_align_o !== 1'b1 || stall_o !== 1'b0 || bus_req_o !== 1'b0) begin
      nFails++;
      $display("FAIL align_exc: exc=%b stall=%b req=%b, want 1 0 0", exc_align_o, stall_o, bus_req_o);
    end
    @(posedge clk); #1;
    mem_write_i = 1'b0;
    @(negedge clk);
    nChecks++;
    if (exc_align_o !== 1'b0 || bus_req_o !== 1'b0 || done_o !== 1'b0) begin
      nFails++;
      $display("FAIL align_after: exc=%b req=%b done=%b, want 0 0 0", exc_align_o, bus_req_o, done_o);
    end
`else
    runAccess("sw_0x102", 1'b0, 1'b1, 2'b00, 1'b0, 32'h102, 32'h1234_5678, 0, 32'h0);
    nChecks++;
    if (bus_addr_o !== 32'h100 || bus_be_o !== 4'b1111 || exc_align_o !== 1'b0) begin
      nFails++;
      $display("FAIL sw_forced_align: addr=%h be=%b exc=%b, want 00000100 1111 0",
               bus_addr_o, bus_be_o, exc_align_o);
    end
`endif
  endtask

  task automatic test_random();
    logic rd, wr, wsel;
    logic [1:0] rsel;
    logic [31:0] addr;
    int ackAt;
    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      rsel = 2'($urandom);
      wsel = 1'($urandom);
      addr = $urandom;
`ifdef MEM_ALIGN_CHECK_EN
      if ((rd && rsel != 2'b01 && rsel != 2'b10) || (!rd && !wsel)) addr[1:0] = 2'b00;
`endif
      ackAt = int'($urandom_range(0, MW + 1)) - 1;
      runAccess($sformatf("rand%0d", i), rd, wr, rsel, wsel, addr, $urandom, ackAt, $urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lw();
    test_byte_loads();
    test_sb();
    test_timeout();
    test_ack_ignored();
    test_reset_mid_req();
    test_align();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
